// File: rtl/nios2_debug_pkg.sv
// Shared definitions for the on-chip debug memory block.
//   - ocimem_state_t : arbitration FSM states
//   - JDO_*          : bit positions of fields inside the 38-bit JTAG data-out word
//   - STATUS_*       : bit positions inside the monitor status register
//   - status_word()  : packs the monitor flags into the 32-bit status read value
package nios2_debug_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_J_RD_ADDR = 3'd1,
    ST_J_RD_DATA = 3'd2,
    ST_J_WR      = 3'd3,
    ST_C_RD_DATA = 3'd4
  } ocimem_state_t;

  localparam int JDO_ADDR_LSB = 10;
  localparam int JDO_RD_BIT   = 35;
  localparam int JDO_GO_BIT   = 25;
  localparam int JDO_DATA_LSB = 3;

  localparam int STATUS_READY_BIT = 0;
  localparam int STATUS_ERROR_BIT = 1;
  localparam int STATUS_GO_BIT    = 2;

  function automatic logic [31:0] status_word(input logic go, input logic err, input logic rdy);
    logic [31:0] w;
    w = '0;
    w[STATUS_GO_BIT]    = go;
    w[STATUS_ERROR_BIT] = err;
    w[STATUS_READY_BIT] = rdy;
    return w;
  endfunction

endpackage

// File: rtl/nios2_debug_ocimem_ram.sv
// Single-port synchronous debug monitor RAM, 32-bit words with byte enables.
// Ports:
//   clk   : clock
//   addr  : word address (registered read: q reflects addr one cycle later)
//   be    : byte write enables (4'b0000 = no write)
//   wdata : write data
//   q     : registered read data (read-before-write on a same-address write)
// No reset on contents or q so the array maps onto block RAM.
module nios2_debug_ocimem_ram
  import nios2_debug_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic [ADDR_W-1:0] addr,
  input  logic [3:0]        be,
  input  logic [31:0]       wdata,
  output logic [31:0]       q
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (be[i]) begin
        mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
      end
    end
    q <= mem[addr];
  end

endmodule

// File: rtl/nios2_debug_ocimem.sv
// On-chip debug memory: owns the debug monitor RAM and the monitor status
// register, arbitrating between JTAG host commands and the CPU's Avalon-MM
// debug-memory slave port.
// Ports:
//   clk, reset_n              : clock, asynchronous active-low reset
//   jdo                       : JTAG data-out word, valid with a take_* pulse
//   take_action_ocimem_a      : load address (optionally read / go)
//   take_no_action_ocimem_a   : auto-increment address and read
//   take_action_ocimem_b      : load write data and write
//   avs_*                     : CPU slave port; avs_address MSB selects status
//   MonDReg                   : JTAG data register returned to the debug slave
//   monitor_ready/error/go    : monitor handshake flags
module nios2_debug_ocimem
  import nios2_debug_pkg::*;
#(
  parameter int   ADDR_W              = 8,
  parameter logic RESET_MONITOR_READY = 1'b0
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [37:0]     jdo,
  input  logic            take_action_ocimem_a,
  input  logic            take_no_action_ocimem_a,
  input  logic            take_action_ocimem_b,
  input  logic [ADDR_W:0] avs_address,
  input  logic            avs_read,
  input  logic            avs_write,
  input  logic [31:0]     avs_writedata,
  input  logic [3:0]      avs_byteenable,
  output logic [31:0]     avs_readdata,
  output logic            avs_waitrequest,
  output logic [31:0]     MonDReg,
  output logic            monitor_ready,
  output logic            monitor_error,
  output logic            monitor_go
);

  ocimem_state_t     state_reg, state_next;
  logic              pend_rd_reg, pend_rd_next;
  logic              pend_wr_reg, pend_wr_next;
  logic [ADDR_W-1:0] mon_a_reg;
  logic [31:0]       readdata_reg;
  logic              out_of_reset_reg;

  logic [ADDR_W-1:0] ram_addr;
  logic [3:0]        ram_be;
  logic [31:0]       ram_wdata;
  logic [31:0]       ram_q;
  logic [31:0]       readdata_next;
  logic              waitrequest_next;

  logic unused_jdo;
  assign unused_jdo = ^{jdo[37:36], jdo[JDO_DATA_LSB-1:0]};

  // JTAG command decode. A pulse in this cycle counts as pending already, so
  // a CPU request arriving together with a JTAG command yields to it.
  logic a_rd, a_go, pulse_rd, pulse_wr, new_cmd, want_rd, want_wr, jtag_want;
  assign a_rd     = take_action_ocimem_a & jdo[JDO_RD_BIT];
  assign a_go     = take_action_ocimem_a & jdo[JDO_GO_BIT];
  assign pulse_rd = a_rd | take_no_action_ocimem_a;
  assign pulse_wr = take_action_ocimem_b;
  assign new_cmd  = pulse_rd | pulse_wr;
  // The newest command replaces any unserved one.
  assign want_rd   = new_cmd ? (pulse_rd & ~pulse_wr) : pend_rd_reg;
  assign want_wr   = new_cmd ? pulse_wr : pend_wr_reg;
  assign jtag_want = want_rd | want_wr;

  // CPU request classification; only granted in IDLE with no JTAG work.
  logic cpu_req, cpu_status, cpu_grant;
  logic cpu_ram_wr, cpu_ram_rd, cpu_stat_rd, cpu_stat_wr;
  assign cpu_req     = out_of_reset_reg & (avs_read | avs_write);
  assign cpu_status  = avs_address[ADDR_W];
  assign cpu_grant   = (state_reg == ST_IDLE) & ~jtag_want & cpu_req;
  assign cpu_ram_wr  = cpu_grant & avs_write & ~cpu_status;
  assign cpu_stat_wr = cpu_grant & avs_write & cpu_status & avs_byteenable[0];
  assign cpu_stat_rd = cpu_grant & ~avs_write & avs_read & cpu_status;
  assign cpu_ram_rd  = cpu_grant & ~avs_write & avs_read & ~cpu_status;

  always_comb begin
    state_next       = state_reg;
    ram_addr         = mon_a_reg;
    ram_be           = 4'b0000;
    ram_wdata        = MonDReg;
    waitrequest_next = 1'b1;
    readdata_next    = readdata_reg;
    pend_rd_next     = want_rd;
    pend_wr_next     = want_wr;

    case (state_reg)
      ST_IDLE: begin
        ram_addr         = avs_address[ADDR_W-1:0];
        waitrequest_next = ~out_of_reset_reg | (cpu_req & jtag_want);
        if (want_rd) begin
          state_next   = ST_J_RD_ADDR;
          pend_rd_next = 1'b0;
        end else if (want_wr) begin
          state_next   = ST_J_WR;
          pend_wr_next = 1'b0;
        end else if (cpu_ram_wr) begin
          ram_be    = avs_byteenable;
          ram_wdata = avs_writedata;
        end else if (cpu_stat_rd) begin
          readdata_next = status_word(monitor_go, monitor_error, monitor_ready);
        end else if (cpu_ram_rd) begin
          // RAM address is the CPU address this cycle; data arrives next cycle.
          waitrequest_next = 1'b1;
          state_next       = ST_C_RD_DATA;
        end
      end
      ST_J_RD_ADDR: begin
        ram_addr   = mon_a_reg;
        state_next = ST_J_RD_DATA;
      end
      ST_J_RD_DATA: begin
        state_next = ST_IDLE;
      end
      ST_J_WR: begin
        ram_addr   = mon_a_reg;
        ram_be     = 4'b1111;
        ram_wdata  = MonDReg;
        state_next = ST_IDLE;
      end
      ST_C_RD_DATA: begin
        waitrequest_next = 1'b0;
        readdata_next    = ram_q;
        state_next       = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Read data is presented combinationally in the completing cycle and then
  // held in readdata_reg until the next read.
  assign avs_readdata    = readdata_next;
  assign avs_waitrequest = waitrequest_next;

  nios2_debug_ocimem_ram #(
    .ADDR_W(ADDR_W)
  ) u_ram (
    .clk  (clk),
    .addr (ram_addr),
    .be   (ram_be),
    .wdata(ram_wdata),
    .q    (ram_q)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg        <= ST_IDLE;
      pend_rd_reg      <= 1'b0;
      pend_wr_reg      <= 1'b0;
      mon_a_reg        <= '0;
      MonDReg          <= '0;
      readdata_reg     <= '0;
      out_of_reset_reg <= 1'b0;
      monitor_ready    <= RESET_MONITOR_READY;
      monitor_error    <= 1'b0;
      monitor_go       <= 1'b0;
    end else begin
      state_reg        <= state_next;
      pend_rd_reg      <= pend_rd_next;
      pend_wr_reg      <= pend_wr_next;
      readdata_reg     <= readdata_next;
      out_of_reset_reg <= 1'b1;

      // A host pulse takes precedence over the FSM's own address/data update.
      if (take_action_ocimem_a) begin
        mon_a_reg <= jdo[JDO_ADDR_LSB +: ADDR_W];
      end else if (take_no_action_ocimem_a || state_reg == ST_J_WR) begin
        mon_a_reg <= mon_a_reg + ADDR_W'(1);
      end

      if (take_action_ocimem_b) begin
        MonDReg <= jdo[JDO_DATA_LSB +: 32];
      end else if (state_reg == ST_J_RD_DATA) begin
        MonDReg <= ram_q;
      end

      // JTAG go beats a same-cycle CPU status write for go/ready.
      if (a_go) begin
        monitor_go    <= 1'b1;
        monitor_ready <= 1'b0;
      end else if (cpu_stat_wr) begin
        monitor_ready <= avs_writedata[STATUS_READY_BIT];
        if (avs_writedata[STATUS_GO_BIT]) begin
          monitor_go <= 1'b0;
        end
      end

      if (cpu_stat_wr) begin
        monitor_error <= avs_writedata[STATUS_ERROR_BIT];
      end
    end
  end

endmodule

// File: tb/tb_nios2_debug_ocimem.sv
module tb_nios2_debug_ocimem;

  localparam int ADDR_W = 8;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [37:0] jdo;
  logic        ta_a, tna_a, ta_b;
  logic [8:0]  avs_address;
  logic        avs_read, avs_write;
  logic [31:0] avs_writedata;
  logic [3:0]  avs_byteenable;
  logic [31:0] avs_readdata;
  logic        avs_waitrequest;
  logic [31:0] MonDReg;
  logic        monitor_ready, monitor_error, monitor_go;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic [31:0] model_mem [256];
  logic [7:0]  model_a;

  always #5 clk = ~clk;

  nios2_debug_ocimem #(
    .ADDR_W(ADDR_W),
    .RESET_MONITOR_READY(1'b0)
  ) dut (
    .clk                    (clk),
    .reset_n                (reset_n),
    .jdo                    (jdo),
    .take_action_ocimem_a   (ta_a),
    .take_no_action_ocimem_a(tna_a),
    .take_action_ocimem_b   (ta_b),
    .avs_address            (avs_address),
    .avs_read               (avs_read),
    .avs_write              (avs_write),
    .avs_writedata          (avs_writedata),
    .avs_byteenable         (avs_byteenable),
    .avs_readdata           (avs_readdata),
    .avs_waitrequest        (avs_waitrequest),
    .MonDReg                (MonDReg),
    .monitor_ready          (monitor_ready),
    .monitor_error          (monitor_error),
    .monitor_go             (monitor_go)
  );

  function automatic logic [37:0] jdo_a(input logic [7:0] addr, input logic rd, input logic go);
    logic [37:0] j;
    j = '0;
    j[17:10] = addr;
    j[35] = rd;
    j[25] = go;
    return j;
  endfunction

  function automatic logic [37:0] jdo_b(input logic [31:0] data);
    logic [37:0] j;
    j = '0;
    j[34:3] = data;
    return j;
  endfunction

  function automatic logic [31:0] merge_be(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (be[i]) r[i*8 +: 8] = nw[i*8 +: 8];
    return r;
  endfunction

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic jtag_cmd(input logic a, input logic na, input logic b, input logic [37:0] j);
    @(negedge clk);
    ta_a = a; tna_a = na; ta_b = b; jdo = j;
    @(posedge clk);
    #1;
    ta_a = 0; tna_a = 0; ta_b = 0; jdo = '0;
  endtask

  // One CPU transfer; returns read data and the number of wait cycles seen.
  task automatic cpu_access(input logic wr, input logic [8:0] addr, input logic [31:0] wd,
                            input logic [3:0] be, output logic [31:0] rd, output int waits);
    @(negedge clk);
    avs_address = addr; avs_writedata = wd; avs_byteenable = be;
    avs_write = wr; avs_read = ~wr;
    waits = 0;
    forever begin
      #1;
      if (!avs_waitrequest) break;
      waits++;
      if (waits >= 50) begin
        n_checks++; n_fail++;
        $display("FAIL cpu_timeout addr=%h waits=%0d required <50", addr, waits);
        break;
      end
      @(negedge clk);
    end
    rd = avs_readdata;
    @(posedge clk);
    #1;
    avs_write = 0; avs_read = 0;
  endtask

  task automatic test_reset;
    reset_n = 0;
    #12;
    n_checks++; if (MonDReg !== 32'h0) begin n_fail++; $display("FAIL reset_mondreg got=%h exp=%h", MonDReg, 32'h0); end
    n_checks++; if (monitor_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready got=%b exp=0", monitor_ready); end
    n_checks++; if (monitor_go !== 1'b0) begin n_fail++; $display("FAIL reset_go got=%b exp=0", monitor_go); end
    n_checks++; if (monitor_error !== 1'b0) begin n_fail++; $display("FAIL reset_error got=%b exp=0", monitor_error); end
    n_checks++; if (avs_readdata !== 32'h0) begin n_fail++; $display("FAIL reset_readdata got=%h exp=0", avs_readdata); end
    n_checks++; if (avs_waitrequest !== 1'b1) begin n_fail++; $display("FAIL reset_wait got=%b exp=1", avs_waitrequest); end
    @(negedge clk);
    reset_n = 1;
    #1;
    n_checks++; if (avs_waitrequest !== 1'b1) begin n_fail++; $display("FAIL release_wait_before_edge got=%b exp=1", avs_waitrequest); end
    @(posedge clk);
    #1;
    n_checks++; if (avs_waitrequest !== 1'b0) begin n_fail++; $display("FAIL release_wait_after_edge got=%b exp=0", avs_waitrequest); end
    $display("reset: MonDReg=%h ready=%b go=%b wait=%b", MonDReg, monitor_ready, monitor_go, avs_waitrequest);
  endtask

  task automatic test_jtag_write;
    logic [31:0] rd;
    int waits;
    jtag_cmd(1, 0, 0, jdo_a(8'hFE, 0, 0));
    model_a = 8'hFE;
    idle(2);
    jtag_cmd(0, 0, 1, jdo_b(32'h11111111));
    model_mem[model_a] = 32'h11111111; model_a = model_a + 8'd1;
    idle(2);
    jtag_cmd(0, 0, 1, jdo_b(32'h22222222));
    model_mem[model_a] = 32'h22222222; model_a = model_a + 8'd1;
    idle(2);
    // third write lands wherever the address wrapped to
    jtag_cmd(0, 0, 1, jdo_b(32'h33333333));
    model_mem[model_a] = 32'h33333333; model_a = model_a + 8'd1;
    idle(2);
    n_checks++; if (MonDReg !== 32'h33333333) begin n_fail++; $display("FAIL jwr_mondreg got=%h exp=%h", MonDReg, 32'h33333333); end
    cpu_access(0, 9'h0FE, 0, 4'hF, rd, waits);
    n_checks++; if (rd !== model_mem[8'hFE]) begin n_fail++; $display("FAIL jwr_ram_fe got=%h exp=%h", rd, model_mem[8'hFE]); end
    cpu_access(0, 9'h0FF, 0, 4'hF, rd, waits);
    n_checks++; if (rd !== model_mem[8'hFF]) begin n_fail++; $display("FAIL jwr_ram_ff got=%h exp=%h", rd, model_mem[8'hFF]); end
    cpu_access(0, 9'h000, 0, 4'hF, rd, waits);
    n_checks++; if (rd !== 32'h33333333) begin n_fail++; $display("FAIL jwr_wrap_ram00 got=%h exp=%h", rd, 32'h33333333); end
    $display("jtag_write: ram[00]=%h after wrap", rd);
  endtask

  task automatic test_jtag_read;
    logic [31:0] old;
    old = MonDReg;
    jtag_cmd(1, 0, 0, jdo_a(8'hFE, 1, 0));
    model_a = 8'hFE;
    @(posedge clk); #1;
    n_checks++; if (MonDReg !== old) begin n_fail++; $display("FAIL jrd_early got=%h exp=%h", MonDReg, old); end
    @(posedge clk); #1;
    n_checks++; if (MonDReg !== model_mem[model_a]) begin n_fail++; $display("FAIL jrd_lat2 got=%h exp=%h", MonDReg, model_mem[model_a]); end
    idle(1);
    jtag_cmd(0, 1, 0, '0);
    model_a = model_a + 8'd1;
    idle(2);
    n_checks++; if (MonDReg !== model_mem[model_a]) begin n_fail++; $display("FAIL jrd_autoinc got=%h exp=%h", MonDReg, model_mem[model_a]); end
    $display("jtag_read: MonDReg=%h addr=%h", MonDReg, model_a);
  endtask

  task automatic test_cpu_byte;
    logic [31:0] rd;
    int waits;
    cpu_access(1, 9'h005, 32'h0, 4'hF, rd, waits);
    model_mem[5] = 32'h0;
    n_checks++; if (waits !== 0) begin n_fail++; $display("FAIL cwr_waits got=%0d exp=0", waits); end
    cpu_access(1, 9'h005, 32'hAABBCCDD, 4'b0010, rd, waits);
    model_mem[5] = merge_be(model_mem[5], 32'hAABBCCDD, 4'b0010);
    cpu_access(0, 9'h005, 0, 4'hF, rd, waits);
    n_checks++; if (rd !== model_mem[5]) begin n_fail++; $display("FAIL cbyte_data got=%h exp=%h", rd, model_mem[5]); end
    n_checks++; if (waits !== 1) begin n_fail++; $display("FAIL cbyte_waits got=%0d exp=1", waits); end
    $display("cpu_byte: rd=%h waits=%0d", rd, waits);
  endtask

  task automatic test_random;
    logic [31:0] rd, d;
    logic [7:0]  a;
    logic [3:0]  be;
    int waits, op;
    for (int i = 16; i < 32; i++) begin
      d = $urandom;
      cpu_access(1, 9'(i), d, 4'hF, rd, waits);
      model_mem[i] = d;
    end
    for (int it = 0; it < 40; it++) begin
      op = $urandom_range(0, 3);
      a  = 8'(16 + $urandom_range(0, 15));
      d  = $urandom;
      be = 4'($urandom_range(0, 15));
      case (op)
        0: begin
          cpu_access(1, {1'b0, a}, d, be, rd, waits);
          model_mem[a] = merge_be(model_mem[a], d, be);
          n_checks++; if (waits !== 0) begin n_fail++; $display("FAIL rnd_cwr_waits a=%h got=%0d exp=0", a, waits); end
          $display("rnd cpu_wr a=%h d=%h be=%b", a, d, be);
        end
        1: begin
          cpu_access(0, {1'b0, a}, 0, 4'hF, rd, waits);
          n_checks++; if (rd !== model_mem[a] || waits !== 1) begin n_fail++; $display("FAIL rnd_crd a=%h got=%h/%0d exp=%h/1", a, rd, waits, model_mem[a]); end
          $display("rnd cpu_rd a=%h d=%h", a, rd);
        end
        2: begin
          jtag_cmd(1, 0, 0, jdo_a(a, 0, 0));
          model_a = a;
          jtag_cmd(0, 0, 1, jdo_b(d));
          model_mem[model_a] = d; model_a = model_a + 8'd1;
          idle(2);
          n_checks++; if (MonDReg !== d) begin n_fail++; $display("FAIL rnd_jwr a=%h got=%h exp=%h", a, MonDReg, d); end
          $display("rnd jtag_wr a=%h d=%h", a, d);
        end
        default: begin
          jtag_cmd(1, 0, 0, jdo_a(a, 1, 0));
          model_a = a;
          idle(3);
          n_checks++; if (MonDReg !== model_mem[a]) begin n_fail++; $display("FAIL rnd_jrd a=%h got=%h exp=%h", a, MonDReg, model_mem[a]); end
          $display("rnd jtag_rd a=%h d=%h", a, MonDReg);
        end
      endcase
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] rd;
    int waits;
    jtag_cmd(1, 0, 0, jdo_a(8'h40, 0, 0));
    model_a = 8'h40;
    idle(1);
    @(negedge clk);
    ta_b = 1; jdo = jdo_b(32'hC0FFEE01);
    avs_read = 1; avs_write = 0; avs_address = 9'h040; avs_byteenable = 4'hF;
    model_mem[model_a] = 32'hC0FFEE01; model_a = model_a + 8'd1;
    waits = 0;
    forever begin
      #1;
      if (!avs_waitrequest) break;
      waits++;
      if (waits >= 50) begin
        n_checks++; n_fail++;
        $display("FAIL b2b_timeout waits=%0d required <50", waits);
        break;
      end
      @(posedge clk); #1;
      ta_b = 0; jdo = '0;
      @(negedge clk);
    end
    rd = avs_readdata;
    @(posedge clk); #1;
    avs_read = 0; ta_b = 0; jdo = '0;
    n_checks++; if (rd !== model_mem[8'h40]) begin n_fail++; $display("FAIL b2b_data got=%h exp=%h", rd, model_mem[8'h40]); end
    n_checks++; if (waits !== 3) begin n_fail++; $display("FAIL b2b_waits got=%0d exp=3", waits); end
    $display("back_to_back: rd=%h waits=%0d", rd, waits);
  endtask

  task automatic test_status;
    logic [31:0] rd;
    int waits;
    jtag_cmd(1, 0, 0, jdo_a(8'h00, 0, 1));
    n_checks++; if (monitor_go !== 1'b1 || monitor_ready !== 1'b0) begin n_fail++; $display("FAIL st_go go/rdy got=%b/%b exp=1/0", monitor_go, monitor_ready); end
    cpu_access(1, 9'h100, 32'h5, 4'b0001, rd, waits);
    n_checks++; if (monitor_go !== 1'b0 || monitor_ready !== 1'b1 || monitor_error !== 1'b0) begin n_fail++; $display("FAIL st_wr go/err/rdy got=%b%b%b exp=001", monitor_go, monitor_error, monitor_ready); end
    cpu_access(0, 9'h100, 0, 4'hF, rd, waits);
    n_checks++; if (rd !== 32'h1 || waits !== 0) begin n_fail++; $display("FAIL st_rd got=%h/%0d exp=00000001/0", rd, waits); end
    // byteenable[0]=0 leaves the register untouched
    cpu_access(1, 9'h100, 32'h2, 4'b1110, rd, waits);
    cpu_access(0, 9'h100, 0, 4'hF, rd, waits);
    n_checks++; if (rd !== 32'h1) begin n_fail++; $display("FAIL st_be0 got=%h exp=00000001", rd); end
    // same-cycle JTAG go and CPU status write
    @(negedge clk);
    ta_a = 1; jdo = jdo_a(8'h00, 0, 1);
    avs_write = 1; avs_read = 0; avs_address = 9'h100; avs_writedata = 32'h3; avs_byteenable = 4'b0001;
    #1;
    n_checks++; if (avs_waitrequest !== 1'b0) begin n_fail++; $display("FAIL st_conflict_wait got=%b exp=0", avs_waitrequest); end
    @(posedge clk); #1;
    ta_a = 0; jdo = '0; avs_write = 0;
    n_checks++; if (monitor_go !== 1'b1 || monitor_ready !== 1'b0 || monitor_error !== 1'b1) begin n_fail++; $display("FAIL st_conflict go/err/rdy got=%b%b%b exp=110", monitor_go, monitor_error, monitor_ready); end
    cpu_access(0, 9'h100, 0, 4'hF, rd, waits);
    n_checks++; if (rd !== 32'h6) begin n_fail++; $display("FAIL st_conflict_rd got=%h exp=00000006", rd); end
    $display("status: rd=%h", rd);
  endtask

  task automatic test_reset_mid;
    jtag_cmd(1, 0, 0, jdo_a(8'h10, 1, 1));
    reset_n = 0;
    #1;
    n_checks++; if (MonDReg !== 32'h0 || monitor_go !== 1'b0 || monitor_error !== 1'b0 || avs_waitrequest !== 1'b1) begin
      n_fail++; $display("FAIL mid_reset got=%h go=%b err=%b wait=%b exp=0 0 0 1", MonDReg, monitor_go, monitor_error, avs_waitrequest);
    end
    @(negedge clk);
    reset_n = 1;
    idle(3);
    n_checks++; if (MonDReg !== 32'h0 || avs_waitrequest !== 1'b0) begin n_fail++; $display("FAIL mid_aborted MonDReg=%h wait=%b exp=0/0", MonDReg, avs_waitrequest); end
    $display("reset_mid: MonDReg=%h wait=%b", MonDReg, avs_waitrequest);
  endtask

  initial begin
    jdo = '0; ta_a = 0; tna_a = 0; ta_b = 0;
    avs_address = '0; avs_read = 0; avs_write = 0; avs_writedata = '0; avs_byteenable = '0;
    model_a = '0;
    test_reset;
    test_jtag_write;
    test_jtag_read;
    test_cpu_byte;
    test_back_to_back;
    test_status;
    test_random;
    test_reset_mid;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
